// File: rtl/hs_burst_source.sv
// Valid/ready burst generator: on start, emits len LFSR words beginning at SEED,
// honouring the handshake hold rule and an optional idle gap between beats.
module hs_burst_source #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [3:0]            gap,
  input  logic                  down_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q, len_nxt;
  logic [3:0]            gap_q, gap_nxt;
  logic [3:0]            gap_cnt, gap_cnt_nxt;
  logic                  valid_nxt;
  logic [WORD_WIDTH-1:0] data_nxt;
  logic                  done_nxt;
  logic [LEN_WIDTH-1:0]  cnt_nxt;
  logic                  accept_c;
  logic                  last_c;
  logic [WORD_WIDTH-1:0] lfsr_c;

  assign accept_c = down_valid && down_ready;
  assign last_c   = (LEN_WIDTH'(beat_cnt + 1'b1) == len_q);
  // Fibonacci LFSR step, taps 7,5,4,3
  assign lfsr_c   = {down_data[WORD_WIDTH-2:0],
                     down_data[7] ^ down_data[5] ^ down_data[4] ^ down_data[3]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (len != '0)) state_nxt = SEND;
      SEND: begin
        if (accept_c) begin
          if (last_c)              state_nxt = IDLE;
          else if (gap_q != 4'd0)  state_nxt = GAP;
        end
      end
      GAP:  if (gap_cnt <= 4'd1) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and burst context
  always_comb begin
    valid_nxt   = down_valid;
    data_nxt    = down_data;
    done_nxt    = 1'b0;
    cnt_nxt     = beat_cnt;
    len_nxt     = len_q;
    gap_nxt     = gap_q;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = '0;
          if (len != '0) begin
            len_nxt   = len;
            gap_nxt   = gap;
            data_nxt  = SEED;
            valid_nxt = 1'b1;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      SEND: begin
        if (accept_c) begin
          cnt_nxt = LEN_WIDTH'(beat_cnt + 1'b1);
          if (last_c) begin
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            data_nxt = lfsr_c;
            if (gap_q != 4'd0) begin
              valid_nxt   = 1'b0;
              gap_cnt_nxt = gap_q;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) valid_nxt   = 1'b1;
        else                 gap_cnt_nxt = 4'(gap_cnt - 4'd1);
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  // Output and context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_cnt   <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      down_valid <= valid_nxt;
      down_data  <= data_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      beat_cnt   <= cnt_nxt;
      len_q      <= len_nxt;
      gap_q      <= gap_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hs_burst_source.sv
// Directed bench for hs_burst_source: per-cycle vector table plus
// hand-written reset-abort and maximum-length sequences.
module tb_hs_burst_source;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [3:0] gap;
  logic       down_ready;
  logic       down_valid;
  logic [7:0] down_data;
  logic       busy;
  logic       done;
  logic [7:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  hs_burst_source #(.WORD_WIDTH(8), .LEN_WIDTH(8), .SEED(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .gap        (gap),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied before an edge; expected outputs seen just after it.
  typedef struct {
    logic       start;
    logic [7:0] len;
    logic [3:0] gap;
    logic       ready;
    logic       v;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [7:0] l, input logic [3:0] g,
                              input logic r, input logic v, input logic [7:0] d,
                              input logic b, input logic dn, input logic [7:0] c);
    vec_t x;
    x.start = s; x.len = l; x.gap = g; x.ready = r;
    x.v = v; x.data = d; x.busy = b; x.done = dn; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // len=4 gap=0 ready=1: A5 4A 95 2A back to back
    vecs.push_back(mk(1, 4, 0, 1, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h4A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h95, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h2A, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 4));
    // len=3 gap=0, consumer stalls three cycles
    vecs.push_back(mk(1, 3, 0, 0, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h4A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h95, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 3));
    // len=3 gap=2: valid 1,0,0,1,0,0,1
    vecs.push_back(mk(1, 3, 2, 1, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h4A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h95, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 3));
    // len=0: done only, counter cleared, never busy
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 0));
    // start re-pulsed mid-burst with len=9 is ignored; later start restarts at A5
    vecs.push_back(mk(1, 2, 0, 0, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(1, 9, 3, 1, 1, 8'h4A, 1, 0, 1));
    vecs.push_back(mk(1, 9, 3, 1, 0, 8'h00, 0, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 1));

    rst = 1'b1; start = 1'b0; len = '0; gap = '0; down_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 0, 32'(down_valid), 32'd0);
    chk("rst_data",  0, 32'(down_data),  32'd0);
    chk("rst_busy",  0, 32'(busy),       32'd0);
    chk("rst_done",  0, 32'(done),       32'd0);
    chk("rst_cnt",   0, 32'(beat_cnt),   32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].start; len = vecs[i].len; gap = vecs[i].gap;
      down_ready = vecs[i].ready;
      tick();
      chk("valid", i, 32'(down_valid), 32'(vecs[i].v));
      if (vecs[i].v) chk("data", i, 32'(down_data), 32'(vecs[i].data));
      chk("busy",  i, 32'(busy),     32'(vecs[i].busy));
      chk("done",  i, 32'(done),     32'(vecs[i].done));
      chk("cnt",   i, 32'(beat_cnt), 32'(vecs[i].cnt));
    end

    // Reset mid-burst after two of five beats
    start = 1'b1; len = 8'd5; gap = 4'd0; down_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_cnt", 0, 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_valid", 0, 32'(down_valid), 32'd0);
    chk("abort_data",  0, 32'(down_data),  32'd0);
    chk("abort_busy",  0, 32'(busy),       32'd0);
    chk("abort_done",  0, 32'(done),       32'd0);
    chk("abort_cnt",   0, 32'(beat_cnt),   32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_done",  k, 32'(done),       32'd0);
      chk("post_rst_valid", k, 32'(down_valid), 32'd0);
      chk("post_rst_busy",  k, 32'(busy),       32'd0);
    end
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    chk("restart_valid", 0, 32'(down_valid), 32'd1);
    chk("restart_data",  0, 32'(down_data),  32'hA5);
    tick();
    chk("restart_done",  0, 32'(done), 32'd1);

    // Maximum-length burst: exactly 255 accepted beats, no wrap
    start = 1'b1; len = 8'd255; gap = 4'd0; down_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("maxlen_edges", 0, 32'(n),        32'd255);
    chk("maxlen_cnt",   0, 32'(beat_cnt), 32'd255);
    chk("maxlen_busy",  0, 32'(busy),     32'd0);
    tick();
    chk("maxlen_hold",  0, 32'(beat_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_burst_source.md
# hs_burst_source

Valid/ready stream transmitter that drives the upstream side of the team's handshake pipeline stages. On a start pulse, it emits a burst of a programmed number of pseudo-random words on a `down_valid`/`down_ready`/`down_data` interface. It obeys the handshake hold rules and inserts an optional idle gap between beats. It serves as the traffic generator that feeds pipeline registers and skid buffers in block-level and system-level benches.

## Interface
- `WORD_WIDTH`, 8: data width; fixed at 8 because the LFSR polynomial is 8-bit.
- `LEN_WIDTH`, 8: width of the burst length and beat counter.
- `SEED`, 8'hA5: first word of every burst; must be nonzero.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  burst request; sampled only in IDLE.
- `len`  in  LEN_WIDTH  beats in the burst; sampled with `start`.
- `gap`  in  4  idle cycles inserted after each accepted beat except the last; sampled with `start`.
- `down_ready`  in  1  consumer ready.
- `down_valid`  out  1  beat valid.
- `down_data`  out  WORD_WIDTH  beat data.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse when a burst completes.
- `beat_cnt`  out  LEN_WIDTH  beats accepted in the current or last burst.

## Operation
- States: IDLE, SEND, GAP. `busy` = (state != IDLE). All outputs are registered.
- IDLE, `start`=1, `len`!=0:
  - latch `len` and `gap`; clear `beat_cnt`; load `down_data`=SEED.
  - set `down_valid`=1; go to SEND.
- IDLE, `start`=1, `len`==0: `done`=1 for one cycle; stay in IDLE; `beat_cnt` cleared; no valid is ever driven.
- SEND: a beat is accepted on a rising edge where `down_valid`&&`down_ready`. On acceptance, `beat_cnt`+1.
  - Last beat (`beat_cnt`+1 == latched len): `down_valid`=0, `done`=1, go to IDLE.
  - Else if latched gap==0: `down_data`=next(`down_data`), `down_valid` stays 1, stay in SEND.
  - Else: `down_valid`=0, `down_data`=next(`down_data`), load gap counter, go to GAP.
- GAP: hold `down_valid`=0 for exactly `gap` cycles, then set `down_valid`=1 and return to SEND. `down_data` already holds the next word.
- Hold rule: while `down_valid`=1 and `down_ready`=0, `down_valid` and `down_data` are stable. `down_valid` never drops without acceptance.
- LFSR next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. The sequence from SEED 8'hA5 is A5, 4A, 95, 2A. The LFSR reloads SEED on every start.
- `start` while busy is ignored and has no effect on the current burst. `len`/`gap` changes mid-burst are ignored.
- `beat_cnt` holds its final value after `done` until the next accepted `start`.

## Timing
- Reset values: `down_valid`=0, `down_data`=0, `busy`=0, `done`=0, `beat_cnt`=0, state IDLE.
- Reset asserted mid-burst aborts immediately, with no `done` pulse. After release the block idles.
- Start latency: `start` high at edge N gives `down_valid`=1 and `busy`=1 from edge N.
- Throughput: one beat per cycle when `gap`=0 and `down_ready`=1.
- Gap beats: the beat accepted at edge M gives `down_valid`=0 for cycles M..M+gap-1 and `down_valid`=1 again from edge M+gap.
- Last beat accepted at edge L: `down_valid`=0, `done`=1, `busy`=0 from edge L for one cycle. A new `start` is accepted from the edge after L.
- `len` = 2^LEN_WIDTH-1 is the maximum burst; the counter does not wrap within a burst.

## Test plan
- `len`=4, `gap`=0, `down_ready`=1 constant -> data A5, 4A, 95, 2A on 4 consecutive cycles; `done` pulses 1 cycle; `beat_cnt`=4.
- `len`=3, `gap`=0, `down_ready` low for 3 cycles after valid rises -> A5 held stable for 3 cycles, then A5, 4A, 95 accepted; no beat lost or duplicated.
- `len`=3, `gap`=2, `down_ready`=1 -> valid pattern 1,0,0,1,0,0,1 with data A5, 4A, 95; `done` after the third beat.
- `len`=0 with `start` -> `done` one cycle, `down_valid` never high, `beat_cnt`=0, `busy` stays 0.
- `start` re-pulsed mid-burst with `len`=9 -> ignored; original burst completes with its latched length. A later start restarts at A5.
- `rst` asserted after 2 of 5 beats -> all outputs 0 immediately, no `done`. A fresh `start` after release sends A5 first.
